morph_window_scheduler: RTL

- Sequences the nine 1-bit SDPB frame buffers that feed the 3x3 AND (erosion) datapath.
- Per pixel: issues the nine neighbourhood read addresses (one per buffer, tap-ordered) and a border mask.
- Emits an output write address, a valid strobe and a last flag, all time-aligned with buffer dout after the RAM read latency.
- Sits between the frame-control logic (start/abort) and the nine Gowin_SDPB read ports, on the PLL clock domain.

---
 rtl/morph_pkg.sv | 19 +
 rtl/morph_tap_delay.sv | 38 +++
 rtl/morph_window_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/morph_pkg.sv
// Shared types and constants for the 3x3 erosion window scheduler.
package morph_pkg;
  localparam int ADDR_W_DEF = 17;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  // Tap index: t = (dy+1)*3 + (dx+1)
  localparam int TAP_NW = 0;
  localparam int TAP_N  = 1;
  localparam int TAP_NE = 2;
  localparam int TAP_W  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_E  = 5;
  localparam int TAP_SW = 6;
  localparam int TAP_S  = 7;
  localparam int TAP_SE = 8;
  localparam int NUM_TAPS = 9;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} st_e;
endpackage

// File: rtl/morph_tap_delay.sv
// RD_LAT-deep shift register aligning {valid, last, mask, centre} with buffer dout.
module morph_tap_delay #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic [8:0]        mask_i,
  input  logic [ADDR_W-1:0] centre_i,
  output logic              valid_o,
  output logic              last_o,
  output logic [8:0]        mask_o,
  output logic [ADDR_W-1:0] centre_o
);
  localparam int PW = 11 + ADDR_W;

  logic [RD_LAT-1:0][PW-1:0] pipe_q;
  logic [PW-1:0]             head;

  // Payload is zeroed when not valid so idle outputs read as 0.
  assign head = valid_i ? {valid_i, last_i, mask_i, centre_i} : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else if (flush_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= head;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {valid_o, last_o, mask_o, centre_o} = pipe_q[RD_LAT-1];
endmodule

// File: rtl/morph_window_scheduler.sv
// Issues nine tap read addresses per pixel to the SDPB buffers and aligns the window strobes.
// Optional MORPH_BORDER_REPLICATE_EN: clamp border taps to the edge pixel instead of masking.
module morph_window_scheduler
  import morph_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 2
) (
  input  logic                  clk_out,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [9*ADDR_W-1:0]   rd_addr,
  output logic                  win_valid,
  output logic [8:0]            win_mask,
  output logic                  win_last,
  output logic [ADDR_W-1:0]     wr_addr
);
  localparam int XW        = $clog2(IMG_W + 1);
  localparam int YW        = $clog2(IMG_H + 1);
  localparam int AW2       = ADDR_W + 2;
  localparam int DRAIN_CYC = 2 * RD_LAT;
  localparam int CW        = $clog2(DRAIN_CYC + 1);

  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_size_chk
    $error("IMG_W*IMG_H does not fit in ADDR_W");
  end
  if (RD_LAT < 1) begin : g_lat_chk
    $error("RD_LAT must be >= 1");
  end

  st_e             state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            issue, last_pix, flush;
  logic            x_lo, x_hi, y_lo, y_hi;
  logic [8:0][ADDR_W-1:0] tap_addr;
  logic [8:0]      tap_mask;
  logic signed [AW2-1:0] c_s;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign x_lo = (x_q == '0);
  assign x_hi = (x_q == XW'(IMG_W - 1));
  assign y_lo = (y_q == '0);
  assign y_hi = (y_q == YW'(IMG_H - 1));

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    issue    = 1'b0;
    last_pix = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = '0;
          y_d     = '0;
          c_d     = '0;
        end
      end
      RUN: begin
        issue    = 1'b1;
        last_pix = x_hi && y_hi;
        c_d      = c_q + 1'b1;
        if (last_pix) begin
          state_d = DRAIN;
          cnt_d   = CW'(DRAIN_CYC - 1);
        end else if (x_hi) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      // Covers the in-flight windows plus the same number of guard cycles for the result write.
      DRAIN: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      flush   = 1'b1;
    end
  end

  assign c_s = $signed({2'b00, c_q});

  always_comb begin
    logic signed [AW2-1:0] tap_sum;
    int   dyi, dxi;
    logic oob_x, oob_y, in_rng;
    tap_addr = '0;
    tap_mask = '0;
    tap_sum  = '0;
    dyi      = 0;
    dxi      = 0;
    oob_x    = 1'b0;
    oob_y    = 1'b0;
    in_rng   = 1'b0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      dyi   = t / 3 - 1;
      dxi   = t % 3 - 1;
      // The x test stops a +/-1 column step from wrapping onto the adjacent row.
      oob_x = (dxi < 0 && x_lo) || (dxi > 0 && x_hi);
      oob_y = (dyi < 0 && y_lo) || (dyi > 0 && y_hi);
`ifdef MORPH_BORDER_REPLICATE_EN
      if (oob_x) dxi = 0;
      if (oob_y) dyi = 0;
`endif
      tap_sum = c_s + AW2'(dyi * IMG_W) + AW2'(dxi);
      in_rng  = (tap_sum[AW2-1:ADDR_W] == '0);
`ifdef MORPH_BORDER_REPLICATE_EN
      tap_mask[t] = 1'b1;
      if (in_rng) tap_addr[t] = tap_sum[ADDR_W-1:0];
`else
      if (!oob_x && !oob_y && in_rng) begin
        tap_mask[t] = 1'b1;
        tap_addr[t] = tap_sum[ADDR_W-1:0];
      end
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rd_en   = issue;
  assign rd_addr = issue ? tap_addr : '0;

  morph_tap_delay #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_delay (
    .clk_i    (clk_out),
    .rst_ni   (rst_n),
    .flush_i  (flush),
    .valid_i  (issue),
    .last_i   (last_pix),
    .mask_i   (tap_mask),
    .centre_i (c_q),
    .valid_o  (win_valid),
    .last_o   (win_last),
    .mask_o   (win_mask),
    .centre_o (wr_addr)
  );
endmodule
